adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter RR_INIT, default 0: requester holding priority after reset (0 or 1).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid  in  1  requester has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  out  1  operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  in  32  operands.
REQ-007 SHALL have ports req0_sub / req1_sub  in  1  1 = A minus B, 0 = A plus B.
REQ-008 SHALL have port rsp_valid  out  1  result buffer holds a result.
REQ-009 SHALL have port rsp_ready  in  1  consumer takes the result.
REQ-010 SHALL have port rsp_sum  out  32  registered result.
REQ-011 SHALL have port rsp_cout  out  1  registered carry-out of bit 31.
REQ-012 SHALL have port rsp_id  out  1  index of the requester that owns the result.

Function
REQ-013 SHALL share one 32-bit Sklansky prefix adder between both requesters: g=a&b', p=a^b', b'=b^{32{sub}}, carry-in=sub.
REQ-014 SHALL be a two-state FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-015 SHALL define accept = rsp_valid==0 or (rsp_valid & rsp_ready).
REQ-016 SHALL assert at most one reqN_ready per cycle, only when accept=1 and that requester is granted.
REQ-017 SHALL grant the only valid requester; when both are valid, SHALL grant the requester holding priority.
REQ-018 SHALL pass priority to the other requester after each grant (round-robin); no grant leaves priority unchanged.
REQ-019 SHALL produce rsp_sum/rsp_cout/rsp_id one cycle after the handshake (latency 1, registered outputs).
REQ-020 SHALL implement these transitions: EMPTY + grant -> FULL; FULL + rsp_ready + grant -> FULL with new result; FULL + rsp_ready + no grant -> EMPTY; FULL + no rsp_ready -> FULL, outputs held stable.
REQ-021 SHALL make readiness combinational from valid, rsp_ready and state, with no dependence on operand values.
REQ-022 SHALL wrap modulo 2^32 with the carry reported in rsp_cout: sub with a>=b gives cout=1, sub with a<b gives cout=0.
REQ-023 SHALL never drop or duplicate an accepted operation, and SHALL sustain throughput of 1 per cycle while rsp_ready=1.

Reset
REQ-024 SHALL on rst_n=0, immediately and independent of clk: state EMPTY, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, priority=RR_INIT; reqN_ready=0 while reset is asserted.
REQ-025 SHALL discard any result that is buffered when reset asserts mid-operation; after deassertion the first grant obeys RR_INIT.

Configuration
REQ-026 SHALL, when ADDER_ARB_OVF_EN is defined, add output rsp_ovf (1 bit): registered signed overflow, (a31==b'31)&(sum31!=a31), with reset value 0 and the same timing as rsp_sum.
REQ-027 SHALL, when ADDER_ARB_OVF_EN is undefined, omit rsp_ovf and its logic entirely; all other behaviour stays identical.

Verification
REQ-028 SHALL test: RR_INIT=0; both valid; req0 = 0xFFFFFFFF + 0x00000001; req1 = 5 - 3; rsp_ready=1 -> cycle1 sum=0x00000000 cout=1 id=0; cycle2 sum=0x00000002 cout=1 id=1.
REQ-029 SHALL test: req0 sub 3 - 5 -> sum=0xFFFFFFFE, cout=0; with ADDER_ARB_OVF_EN, 0x7FFFFFFF + 1 -> rsp_ovf=1.
REQ-030 SHALL test: rsp_ready=0 for 4 cycles with one result buffered and both requesters valid -> both readies stay 0, outputs stay constant; rsp_ready=1 -> next grant goes to the non-last-granted requester.
REQ-031 SHALL test: only req1 valid continuously for 10 cycles with rsp_ready=1 -> 10 results with id=1 on consecutive cycles, no bubbles.
REQ-032 SHALL test: rst_n pulsed low mid-stream while in FULL -> rsp_valid drops in the same cycle without a clock edge; after release the first grant follows RR_INIT.
REQ-033 SHALL test: 10k random cycles of random valid/ready/operands against a reference model -> results match exactly, in order, with none lost.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one 32-bit Sklansky prefix adder behind a one-entry result buffer.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid / reqN_ready       per-requester handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_sub      operands; sub=1 computes a - b
//   rsp_valid / rsp_ready         result buffer handshake
//   rsp_sum, rsp_cout, rsp_id     registered result, carry-out and owning requester
//   rsp_ovf                       registered signed overflow (only with ADDER_ARB_OVF_EN)
// Parameter RR_INIT selects which requester holds priority after reset.
// Define ADDER_ARB_OVF_EN to add the rsp_ovf output.
module adder_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_sub,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_sum,
    output logic        rsp_cout,
`ifdef ADDER_ARB_OVF_EN
    output logic        rsp_ovf,
`endif
    output logic        rsp_id
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state, state_nxt;
    logic        prio;
    logic        accept, gnt0, gnt1, fire;
    logic [31:0] op_a, op_b, b_eff;
    logic        op_sub;
    logic [32:0] res;

    // Sklansky prefix tree: at level l every bit whose index has bit l set
    // combines with the topmost bit of the lower half of its 2^(l+1) block.
    function automatic logic [32:0] sklansky(input logic [31:0] a, input logic [31:0] b, input logic cin);
        logic [31:0] p, gg, pp, gn, pn;
        logic [32:0] c;
        int          j;
        p  = a ^ b;
        gg = a & b;
        pp = p;
        for (int l = 0; l < 5; l++) begin
            gn = gg;
            pn = pp;
            for (int i = 0; i < 32; i++) begin
                if (((i >> l) & 1) != 0) begin
                    j = ((i >> l) << l) - 1;
                    gn[i[4:0]] = gg[i[4:0]] | (pp[i[4:0]] & gg[j[4:0]]);
                    pn[i[4:0]] = pp[i[4:0]] & pp[j[4:0]];
                end
            end
            gg = gn;
            pp = pn;
        end
        c[0] = cin;
        for (int i = 0; i < 32; i++)
            c[i+1] = gg[i[4:0]] | (pp[i[4:0]] & cin);
        return {c[32], p ^ c[31:0]};
    endfunction

    assign rsp_valid  = (state == FULL);
    assign accept     = !rsp_valid || rsp_ready;
    // prio=0 favours requester 0, prio=1 favours requester 1
    assign gnt1       = req1_valid && (!req0_valid || prio);
    assign gnt0       = req0_valid && !gnt1;
    // readiness is forced low while reset is held
    assign req0_ready = rst_n && accept && gnt0;
    assign req1_ready = rst_n && accept && gnt1;
    assign fire       = req0_ready || req1_ready;

    assign op_a   = gnt1 ? req1_a   : req0_a;
    assign op_b   = gnt1 ? req1_b   : req0_b;
    assign op_sub = gnt1 ? req1_sub : req0_sub;
    assign b_eff  = op_b ^ {32{op_sub}};
    assign res    = sklansky(op_a, b_eff, op_sub);

    always_comb begin
        state_nxt = state;
        state_nxt = fire ? FULL : (rsp_ready ? EMPTY : state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            prio     <= RR_INIT;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
            rsp_ovf  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (fire) begin
                prio     <= !gnt1;
                rsp_sum  <= res[31:0];
                rsp_cout <= res[32];
                rsp_id   <= gnt1;
`ifdef ADDER_ARB_OVF_EN
                rsp_ovf  <= (op_a[31] == b_eff[31]) && (res[31] != op_a[31]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed table, corner sequences and random model check for adder_arbiter.
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req0_ready, req0_sub, req1_valid, req1_ready, req1_sub;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_cout, rsp_id;
    logic [31:0] rsp_sum;
`ifdef ADDER_ARB_OVF_EN
    logic        rsp_ovf;
`endif

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    adder_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
`ifdef ADDER_ARB_OVF_EN
        .rsp_ovf(rsp_ovf),
`endif
        .rsp_id(rsp_id)
    );

    typedef struct {
        logic        v0, s0;
        logic [31:0] a0, b0;
        logic        v1, s1;
        logic [31:0] a1, b1;
        logic        rr, er0, er1, ev;
        logic [31:0] esum;
        logic        ecout, eid, eovf;
    } vec_t;

    vec_t vecs [6];

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // check readies shortly after the inputs change, then advance past the next rising edge
    task automatic pre(input logic e0, input logic e1);
        #1;
        chk1("req0_ready", req0_ready, e0);
        chk1("req1_ready", req1_ready, e1);
        @(posedge clk);
        #1;
    endtask

    task automatic post(input logic ev, input logic [31:0] es, input logic ec, input logic ei);
        chk1("rsp_valid", rsp_valid, ev);
        chk32("rsp_sum", rsp_sum, es);
        chk1("rsp_cout", rsp_cout, ec);
        chk1("rsp_id", rsp_id, ei);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    logic        m_valid, m_prio, m_cout, m_id, m_ovf;
    logic [31:0] m_sum;
    logic        acc, g0, g1, s;
    logic [31:0] a, bx;
    logic [32:0] full;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h1, 1'b1, 1'b1, 32'd5, 32'd3, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h1, 1'b1, 1'b1, 32'd5, 32'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'd3, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 32'd10, 32'd20, 1'b1, 1'b0, 32'd100, 32'd200, 1'b0, 1'b0, 1'b1, 1'b1, 32'd300, 1'b0, 1'b1, 1'b0};

        req0_valid = 1'b1; req1_valid = 1'b1; req0_sub = 1'b0; req1_sub = 1'b0;
        req0_a = 32'd1; req0_b = 32'd1; req1_a = 32'd2; req1_b = 32'd2; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk1("reset req0_ready", req0_ready, 1'b0);
        chk1("reset req1_ready", req1_ready, 1'b0);
        post(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;

        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req0_valid = vecs[k].v0; req0_sub = vecs[k].s0; req0_a = vecs[k].a0; req0_b = vecs[k].b0;
            req1_valid = vecs[k].v1; req1_sub = vecs[k].s1; req1_a = vecs[k].a1; req1_b = vecs[k].b1;
            rsp_ready = vecs[k].rr;
            pre(vecs[k].er0, vecs[k].er1);
            post(vecs[k].ev, vecs[k].esum, vecs[k].ecout, vecs[k].eid);
`ifdef ADDER_ARB_OVF_EN
            chk1("rsp_ovf", rsp_ovf, vecs[k].eovf);
`endif
        end

        // buffered result from requester 1 stalls; priority now with requester 0
        @(negedge clk);
        req0_valid = 1'b1; req0_sub = 1'b0; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_sub = 1'b0; req1_a = 32'd9; req1_b = 32'd9;
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            pre(1'b0, 1'b0);
            post(1'b1, 32'd300, 1'b0, 1'b1);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        pre(1'b1, 1'b0);
        post(1'b1, 32'd2, 1'b0, 1'b0);

        // back-to-back results from a lone requester
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req0_valid = 1'b0;
            req1_valid = 1'b1; req1_sub = 1'b0; req1_a = 32'(k * 3); req1_b = 32'd7;
            pre(1'b0, 1'b1);
            post(1'b1, 32'(k * 3 + 7), 1'b0, 1'b1);
        end

        // asynchronous reset while FULL
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async rsp_valid", rsp_valid, 1'b0);
        chk32("async rsp_sum", rsp_sum, 32'h0);
        chk1("async rsp_id", rsp_id, 1'b0);
        chk1("async req0_ready", req0_ready, 1'b0);
        chk1("async req1_ready", req1_ready, 1'b0);
        @(posedge clk);
        #1;
        chk1("held rsp_valid", rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("post-reset req0_ready", req0_ready, 1'b1);
        chk1("post-reset req1_ready", req1_ready, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;
        post(1'b0, 32'h0, 1'b0, 1'b0);

        m_valid = 1'b0; m_prio = 1'b0; m_sum = 32'h0; m_cout = 1'b0; m_id = 1'b0; m_ovf = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
            req0_sub = 1'($urandom_range(0, 1)); req1_sub = 1'($urandom_range(0, 1));
            req0_a = pick(); req0_b = pick(); req1_a = pick(); req1_b = pick();
            rsp_ready = 1'($urandom_range(0, 1));
            acc = !m_valid || rsp_ready;
            g1 = req1_valid && (!req0_valid || m_prio);
            g0 = req0_valid && !g1;
            a  = g1 ? req1_a : req0_a;
            s  = g1 ? req1_sub : req0_sub;
            bx = g1 ? req1_b : req0_b;
            full = {1'b0, a} + (s ? {1'b0, ~bx} + 33'd1 : {1'b0, bx});
            pre(acc && g0, acc && g1);
            if (acc && (g0 || g1)) begin
                m_valid = 1'b1;
                m_sum = full[31:0];
                m_cout = full[32];
                m_id = g1;
                m_ovf = s ? (a[31] != bx[31]) && (full[31] != a[31]) : (a[31] == bx[31]) && (full[31] != a[31]);
                m_prio = !g1;
            end else if (acc) m_valid = 1'b0;
            post(m_valid, m_sum, m_cout, m_id);
`ifdef ADDER_ARB_OVF_EN
            chk1("rsp_ovf", rsp_ovf, m_ovf);
`endif
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
